// File: rtl/gg_trigger_seq.sv
// gg_trigger_seq: delayed trigger pulse generator with offset/width sweeps.
// Ports: clk, rst_n, enable, mode, cfg_* ranges/step, trig_in -> pulse_out, busy, cur_offset/width, missed_cnt.
package gg_fpga;
  typedef enum logic [1:0] {
    STATIC          = 2'd0,
    BOUNCE_BACK     = 2'd1,
    HIT_WIDTH_SHIFT = 2'd2,
    MODE_RSVD       = 2'd3
  } trigger_mode_t;
endpackage

module gg_trigger_seq
  import gg_fpga::*;
#(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  trigger_mode_t     mode,
  input  logic [CNT_W-1:0]  cfg_offset_min,
  input  logic [CNT_W-1:0]  cfg_offset_max,
  input  logic [CNT_W-1:0]  cfg_width_min,
  input  logic [CNT_W-1:0]  cfg_width_max,
  input  logic [CNT_W-1:0]  cfg_step,
  input  logic              trig_in,
  output logic              pulse_out,
  output logic              busy,
  output logic [CNT_W-1:0]  cur_offset,
  output logic [CNT_W-1:0]  cur_width,
  output logic [MISS_W-1:0] missed_cnt
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PULSE
  } state_t;

  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [MISS_W-1:0] M_ONE = MISS_W'(1);
  localparam logic [MISS_W-1:0] M_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_down;
  logic             loaded;
  trigger_mode_t    prev_mode;

  logic             mode_chg;
  logic             reload;
  logic [CNT_W-1:0] use_off;
  logic [CNT_W-1:0] use_wid;
  logic [CNT_W:0]   off_up;
  logic [CNT_W:0]   off_lo;
  logic [CNT_W:0]   wid_up;
  logic             off_ok;
  logic             wid_ok;
  logic [CNT_W-1:0] nxt_off;
  logic [CNT_W-1:0] nxt_wid;
  logic             nxt_down;

  assign busy     = (state != S_IDLE);
  assign mode_chg = (mode != prev_mode);
  assign reload   = !loaded || mode_chg;

  // a reload and a trigger on the same edge fire with the min values
  assign use_off = reload ? cfg_offset_min : cur_offset;
  assign use_wid = reload ? cfg_width_min : cur_width;

  // one extra bit so sums near 2^CNT_W clamp instead of wrapping
  assign off_up = {1'b0, cur_offset} + {1'b0, cfg_step};
  assign off_lo = {1'b0, cfg_offset_min} + {1'b0, cfg_step};
  assign wid_up = {1'b0, cur_width} + {1'b0, cfg_step};

  assign off_ok = (cfg_offset_min <= cfg_offset_max) && (cfg_step != '0);
  assign wid_ok = (cfg_width_min <= cfg_width_max) && (cfg_step != '0);

  // pulse lasts max(w,1) cycles; counter holds cycles remaining minus one
  function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - C_ONE;
  endfunction

  always_comb begin
    nxt_off  = cfg_offset_min;
    nxt_wid  = cfg_width_min;
    nxt_down = dir_down;
    unique case (1'b1)
      mode == BOUNCE_BACK: begin
        if (!off_ok) begin
          nxt_down = 1'b0;
        end else if (!dir_down) begin
          if (off_up >= {1'b0, cfg_offset_max}) begin
            nxt_off  = cfg_offset_max;
            nxt_down = 1'b1;
          end else begin
            nxt_off = off_up[CNT_W-1:0];
          end
        end else if ({1'b0, cur_offset} <= off_lo) begin
          nxt_down = 1'b0;
        end else begin
          nxt_off = cur_offset - cfg_step;
        end
      end
      mode == HIT_WIDTH_SHIFT: begin
        if (wid_ok && wid_up <= {1'b0, cfg_width_max})
          nxt_wid = wid_up[CNT_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pulse_out  <= 1'b0;
      cur_offset <= '0;
      cur_width  <= '0;
      dir_down   <= 1'b0;
      loaded     <= 1'b0;
      prev_mode  <= STATIC;
      missed_cnt <= '0;
    end else if (!enable) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pulse_out  <= 1'b0;
      cur_offset <= cfg_offset_min;
      cur_width  <= cfg_width_min;
      dir_down   <= 1'b0;
      loaded     <= 1'b1;
      prev_mode  <= mode;
    end else begin
      if (busy && trig_in && missed_cnt != M_MAX)
        missed_cnt <= missed_cnt + M_ONE;
      unique case (state)
        S_IDLE: begin
          if (reload) begin
            cur_offset <= cfg_offset_min;
            cur_width  <= cfg_width_min;
            dir_down   <= 1'b0;
            loaded     <= 1'b1;
            prev_mode  <= mode;
          end
          if (trig_in) begin
            if (use_off == '0) begin
              state     <= S_PULSE;
              pulse_out <= 1'b1;
              cnt       <= last_of(use_wid);
            end else begin
              state <= S_DELAY;
              cnt   <= use_off - C_ONE;
            end
          end
        end
        S_DELAY: begin
          if (cnt == '0) begin
            state     <= S_PULSE;
            pulse_out <= 1'b1;
            cnt       <= last_of(cur_width);
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            pulse_out <= 1'b0;
            if (mode_chg) begin
              cur_offset <= cfg_offset_min;
              cur_width  <= cfg_width_min;
              dir_down   <= 1'b0;
              prev_mode  <= mode;
            end else begin
              cur_offset <= nxt_off;
              cur_width  <= nxt_wid;
              dir_down   <= nxt_down;
            end
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        default: begin
          state     <= S_IDLE;
          pulse_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gg_trigger_seq.sv
// tb_gg_trigger_seq: directed bench for gg_trigger_seq.
// Event-window reference model compared every cycle plus literal checks.
module tb_gg_trigger_seq;
  import gg_fpga::*;

  localparam int CW = 16;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          trig_in = 1'b0;
  trigger_mode_t mode = STATIC;
  logic [CW-1:0] cfg_offset_min = '0;
  logic [CW-1:0] cfg_offset_max = '0;
  logic [CW-1:0] cfg_width_min = '0;
  logic [CW-1:0] cfg_width_max = '0;
  logic [CW-1:0] cfg_step = '0;
  logic          pulse_out;
  logic          busy;
  logic [CW-1:0] cur_offset;
  logic [CW-1:0] cur_width;
  logic [MW-1:0] missed_cnt;

  int tests = 0;
  int fails = 0;

  gg_trigger_seq #(.CNT_W(CW), .MISS_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .cfg_offset_min(cfg_offset_min), .cfg_offset_max(cfg_offset_max),
    .cfg_width_min(cfg_width_min), .cfg_width_max(cfg_width_max),
    .cfg_step(cfg_step), .trig_in(trig_in), .pulse_out(pulse_out),
    .busy(busy), .cur_offset(cur_offset), .cur_width(cur_width),
    .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: an accepted trigger at edge k owns edges k+1..k+off+w
  int            n_edge = 0;
  int            m_k, m_off, m_w, m_end;
  int            m_cur_off, m_cur_w, m_missed;
  bit            m_active, m_down, m_loaded;
  trigger_mode_t m_prev;

  function automatic void m_reset();
    m_active = 0; m_cur_off = 0; m_cur_w = 0; m_down = 0;
    m_missed = 0; m_prev = STATIC; m_loaded = 0;
    m_k = 0; m_off = 0; m_w = 0; m_end = 0;
  endfunction

  function automatic void m_reload();
    m_cur_off = int'(cfg_offset_min);
    m_cur_w   = int'(cfg_width_min);
    m_down    = 0;
  endfunction

  function automatic void m_advance();
    int omin, omax, wmin, wmax, st;
    omin = int'(cfg_offset_min); omax = int'(cfg_offset_max);
    wmin = int'(cfg_width_min);  wmax = int'(cfg_width_max);
    st = int'(cfg_step);
    case (mode)
      BOUNCE_BACK: begin
        m_cur_w = wmin;
        if (omin > omax || st == 0) begin
          m_cur_off = omin; m_down = 0;
        end else if (!m_down) begin
          if (m_cur_off + st >= omax) begin m_cur_off = omax; m_down = 1; end
          else m_cur_off = m_cur_off + st;
        end else begin
          if (m_cur_off <= omin + st) begin m_cur_off = omin; m_down = 0; end
          else m_cur_off = m_cur_off - st;
        end
      end
      HIT_WIDTH_SHIFT: begin
        m_cur_off = omin;
        if (wmin > wmax || st == 0) m_cur_w = wmin;
        else if (m_cur_w + st > wmax) m_cur_w = wmin;
        else m_cur_w = m_cur_w + st;
      end
      default: begin
        m_cur_off = omin; m_cur_w = wmin;
      end
    endcase
  endfunction

  function automatic void m_edge();
    n_edge++;
    if (!enable) begin
      m_active = 0; m_reload(); m_prev = mode; m_loaded = 1;
    end else if (m_active) begin
      if (trig_in && m_missed < 255) m_missed++;
      if (n_edge == m_end) begin
        m_active = 0;
        if (mode != m_prev) begin m_reload(); m_prev = mode; end
        else m_advance();
      end
    end else begin
      if (!m_loaded || mode != m_prev) begin
        m_reload(); m_loaded = 1; m_prev = mode;
      end
      if (trig_in) begin
        m_active = 1; m_k = n_edge; m_off = m_cur_off;
        m_w = (m_cur_w == 0) ? 1 : m_cur_w;
        m_end = n_edge + m_off + m_w;
      end
    end
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model pulse_out", int'(pulse_out),
            int'(m_active && n_edge >= m_k + m_off));
      check("model busy", int'(busy), int'(m_active));
      check("model cur_offset", int'(cur_offset), m_cur_off);
      check("model cur_width", int'(cur_width), m_cur_w);
      check("model missed_cnt", int'(missed_cnt), m_missed);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire();
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int c = 0;
    while (busy && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("wait idle", int'(busy), 0);
  endtask

  // sample pulse/busy at the n negedges following the trigger edge
  task automatic capture(input int n, output logic [15:0] p,
                         output logic [15:0] b);
    p = '0; b = '0;
    fire();
    for (int j = 0; j < n; j++) begin
      p = {p[14:0], pulse_out};
      b = {b[14:0], busy};
      if (j < n - 1) @(negedge clk);
    end
  endtask

  task automatic set_cfg(input int omin, input int omax, input int wmin,
                         input int wmax, input int st);
    cfg_offset_min = CW'(omin); cfg_offset_max = CW'(omax);
    cfg_width_min = CW'(wmin);  cfg_width_max = CW'(wmax);
    cfg_step = CW'(st);
  endtask

  initial begin
    logic [15:0] p, b;
    int used[8];
    int exp_b[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
    int exp_h[5] = '{1, 3, 5, 1, 3};
    int np;
    logic prev;

    #2;
    check("reset pulse_out", int'(pulse_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset cur_offset", int'(cur_offset), 0);
    check("reset cur_width", int'(cur_width), 0);
    check("reset missed_cnt", int'(missed_cnt), 0);

    set_cfg(3, 10, 2, 5, 4);
    mode = STATIC;
    cyc(2);
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(2);
    check("load cur_offset", int'(cur_offset), 3);
    check("load cur_width", int'(cur_width), 2);

    capture(7, p, b);
    check("static pulse pattern", int'(p), 16'h000C);
    check("static busy pattern", int'(b), 16'h007C);
    check("static cur_offset", int'(cur_offset), 3);
    check("static cur_width", int'(cur_width), 2);

    mode = BOUNCE_BACK;
    set_cfg(0, 10, 1, 5, 4);
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      used[i] = int'(cur_offset);
      fire();
      wait_idle(20);
      cyc(1);
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("bounce offset %0d", i), used[i], exp_b[i]);

    mode = HIT_WIDTH_SHIFT;
    set_cfg(0, 10, 1, 5, 2);
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      used[i] = int'(cur_width);
      fire();
      wait_idle(20);
      cyc(1);
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("shift width %0d", i), used[i], exp_h[i]);

    mode = STATIC;
    set_cfg(5, 10, 4, 5, 1);
    cyc(2);
    np = 0;
    prev = 1'b0;
    for (int j = 0; j < 30; j++) begin
      trig_in = (j % 3 == 0) && (j < 18);
      @(negedge clk);
      if (pulse_out && !prev) np++;
      prev = pulse_out;
    end
    trig_in = 1'b0;
    check("burst pulse count", np, 2);
    check("burst missed_cnt", int'(missed_cnt), 4);

    trig_in = 1'b1;
    cyc(320);
    trig_in = 1'b0;
    check("missed saturate", int'(missed_cnt), 255);
    wait_idle(20);

    mode = HIT_WIDTH_SHIFT;
    set_cfg(2, 10, 1, 5, 2);
    cyc(2);
    fire();
    wait_idle(20);
    cyc(1);
    check("pre-drop width", int'(cur_width), 3);
    fire();
    cyc(2);
    check("mid pulse high", int'(pulse_out), 1);
    enable = 1'b0;
    cyc(1);
    check("drop pulse_out", int'(pulse_out), 0);
    check("drop busy", int'(busy), 0);
    check("drop cur_width", int'(cur_width), 1);
    check("drop cur_offset", int'(cur_offset), 2);
    enable = 1'b1;
    cyc(2);

    mode = STATIC;
    set_cfg(4, 10, 2, 5, 1);
    cyc(2);
    fire();
    check("delay busy", int'(busy), 1);
    check("delay pulse_out", int'(pulse_out), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async pulse_out", int'(pulse_out), 0);
    check("async busy", int'(busy), 0);
    check("async cur_offset", int'(cur_offset), 0);
    check("async cur_width", int'(cur_width), 0);
    check("async missed_cnt", int'(missed_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    check("reload after reset", int'(cur_offset), 4);

    enable = 1'b0;
    trig_in = 1'b1;
    cyc(3);
    trig_in = 1'b0;
    check("disabled trig missed", int'(missed_cnt), 0);
    check("disabled trig busy", int'(busy), 0);
    enable = 1'b1;
    cyc(2);

    set_cfg(0, 10, 0, 5, 1);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
    capture(3, p, b);
    check("zero width pulse", int'(p), 16'h0004);
    check("zero width busy", int'(b), 16'h0004);

    mode = BOUNCE_BACK;
    set_cfg(0, 16'hFFFF, 0, 5, 16'hFFFF);
    cyc(2);
    fire();
    wait_idle(20);
    check("clamp offset max", int'(cur_offset), 16'hFFFF);

    set_cfg(6, 2, 1, 5, 3);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
    fire();
    wait_idle(20);
    check("inverted range hold", int'(cur_offset), 6);

    set_cfg(0, 10, 1, 5, 4);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
    fire();
    mode = HIT_WIDTH_SHIFT;
    wait_idle(20);
    check("busy mode change width", int'(cur_width), 1);
    cyc(1);

    set_cfg(0, 10, 1, 16'hFFFF, 16'hFFFF);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
    fire();
    wait_idle(20);
    check("width no wrap", int'(cur_width), 1);

    mode = MODE_RSVD;
    set_cfg(1, 10, 2, 5, 1);
    cyc(2);
    fire();
    wait_idle(20);
    check("reserved offset", int'(cur_offset), 1);

    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gg_trigger_seq.md
GG_TRIGGER_SEQ -- requirements
Module: gg_trigger_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all offset/width/step config and status values.
REQ-002 SHALL have parameter MISS_W, default 8, width of missed-trigger counter.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have: enable  in  1  sequencer enable; low aborts and rearms.
REQ-006 SHALL have: mode  in  2  gg_fpga::trigger_mode_t (STATIC=0, BOUNCE_BACK=1, HIT_WIDTH_SHIFT=2, value 3 reserved).
REQ-007 SHALL have: cfg_offset_min, cfg_offset_max  in  CNT_W each  delay range, cycles.
REQ-008 SHALL have: cfg_width_min, cfg_width_max  in  CNT_W each  pulse-width range, cycles.
REQ-009 SHALL have: cfg_step  in  CNT_W  per-event increment.
REQ-010 SHALL have: trig_in  in  1  trigger event, one cycle per event.
REQ-011 SHALL have: pulse_out  out  1  registered output pulse.
REQ-012 SHALL have: busy  out  1  high in DELAY or PULSE.
REQ-013 SHALL have: cur_offset, cur_width  out  CNT_W each  values used for next/current pulse.
REQ-014 SHALL have: missed_cnt  out  MISS_W  triggers dropped while busy, saturating.

Function
REQ-015 SHALL implement FSM IDLE -> DELAY -> PULSE -> IDLE; busy = (state != IDLE).
REQ-016 IDLE: trig_in && enable at edge k SHALL enter DELAY; pulse_out high exactly cycles k+1+cur_offset .. k+cur_offset+eff_width.
REQ-017 eff_width SHALL be max(cur_width,1); width 0 never yields zero-length pulse.
REQ-018 cur_offset = 0 SHALL give pulse_out high in cycle k+1 (DELAY occupies zero cycles).
REQ-019 cur_offset/cur_width SHALL be frozen from DELAY entry until PULSE exit; update applies on PULSE->IDLE edge only.
REQ-020 STATIC (and reserved 3): cur_offset = cfg_offset_min, cur_width = cfg_width_min after every event.
REQ-021 BOUNCE_BACK: cur_width = cfg_width_min; direction up: if cur_offset+step >= cfg_offset_max then cur_offset = max, dir = down, else cur_offset += step.
REQ-022 BOUNCE_BACK down: if cur_offset <= cfg_offset_min+step then cur_offset = min, dir = up, else cur_offset -= step.
REQ-023 HIT_WIDTH_SHIFT: cur_offset = cfg_offset_min; cur_width += step; if result > cfg_width_max then cur_width = cfg_width_min (wrap).
REQ-024 All sums SHALL be computed in CNT_W+1 bits; no silent wrap at 2^CNT_W.
REQ-025 min > max or step = 0 for the active range SHALL hold cur value at min (no sweep).
REQ-026 trig_in while busy SHALL increment missed_cnt, saturating at 2^MISS_W-1; trigger not queued.
REQ-027 trig_in in the cycle of PULSE->IDLE SHALL count as missed.
REQ-028 mode change (mode != registered previous mode) in IDLE SHALL reload cur_offset/cur_width to min, dir = up; mode change while busy SHALL take effect at PULSE exit, replacing the mode update.
REQ-029 enable low SHALL force IDLE next edge, pulse_out low, reload cur values to min, dir = up; missed_cnt held.
REQ-030 trig_in with enable low SHALL be ignored and not counted.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, pulse_out 0, busy 0, cur_offset 0, cur_width 0, dir up, missed_cnt 0, previous mode STATIC.
REQ-032 First IDLE cycle after reset release with enable high SHALL load cur values from cfg min before any trigger is accepted.
REQ-033 Reset mid-pulse SHALL drop pulse_out immediately (asynchronously).

Verification
REQ-034 STATIC, offset_min 3, width_min 2, trig at edge 10 -> pulse_out high cycles 14-15, busy 11-15, cur unchanged.
REQ-035 BOUNCE_BACK, offset 0..10, step 4, 8 triggers -> cur_offset sequence 0,4,8,10,6,2,0,4.
REQ-036 HIT_WIDTH_SHIFT, width 1..5, step 2, 5 triggers -> widths used 1,3,5,1,3.
REQ-037 offset 5, width 4, trig every 3 cycles x6 -> 2 pulses, missed_cnt increments per dropped trig, saturates at 255 under continuous trig.
REQ-038 enable dropped mid-PULSE -> pulse_out 0 next cycle, cur back to min; rst_n pulsed mid-DELAY -> all outputs reset values same cycle.
REQ-039 width_min 0 -> 1-cycle pulse; offset_max 0xFFFF, step 0xFFFF -> clamps to max, no wrap.
